// File: rtl/fdc_sd_arbiter.sv
// Round-robin arbiter: four wd1793 drive SD block requests share one host SD block port.
// Optional host-ack watchdog: define FDC_SD_TIMEOUT_EN.
module fdc_sd_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] req_lba [4],
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_wr,
    output logic [3:0]  req_ack,
    input  logic [7:0]  req_buff_din [4],
    output logic [3:0]  req_buff_wr,
    output logic [31:0] host_lba,
    output logic [1:0]  host_drive,
    output logic        host_rd,
    output logic        host_wr,
    input  logic        host_ack,
    input  logic        host_buff_wr,
    output logic [7:0]  host_buff_din,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [1:0]  grant_r;
    logic [1:0]  last_grant_r;
    logic [31:0] host_lba_r;
    logic        host_rd_r;
    logic        host_wr_r;
    logic        busy_r;

    logic [3:0]  pending_s;
    logic [1:0]  next_s;
    logic        found_s;
    logic        active_s;

    assign pending_s = req_rd | req_wr;
    assign active_s  = (state_r == ST_REQ) || (state_r == ST_XFER);

    // Round-robin search starting one past the last served drive.
    always_comb begin
        logic [1:0] idx_v;
        next_s  = 2'd0;
        found_s = 1'b0;
        idx_v   = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_v = last_grant_r + i[1:0];
            if (pending_s[idx_v] && !found_s) begin
                next_s  = idx_v;
                found_s = 1'b1;
            end else begin
                next_s  = next_s;
            end
        end
    end

`ifdef FDC_SD_TIMEOUT_EN
    logic [23:0] wd_cnt_r;
    logic        timeout_err_r;
`endif

    // Arbitration FSM with registered host-side outputs.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            grant_r      <= 2'd0;
            last_grant_r <= 2'd3;
            host_lba_r   <= 32'd0;
            host_rd_r    <= 1'b0;
            host_wr_r    <= 1'b0;
            busy_r       <= 1'b0;
`ifdef FDC_SD_TIMEOUT_EN
            wd_cnt_r      <= 24'd0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
`ifdef FDC_SD_TIMEOUT_EN
            timeout_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r    <= next_s;
                        host_lba_r <= req_lba[next_s];
                        // Read takes precedence when both strobes are up.
                        host_rd_r  <= req_rd[next_s];
                        host_wr_r  <= ~req_rd[next_s];
                        busy_r     <= 1'b1;
                        state_r    <= ST_REQ;
`ifdef FDC_SD_TIMEOUT_EN
                        wd_cnt_r   <= 24'd0;
`endif
                    end
                end
                ST_REQ: begin
                    if (host_ack) begin
                        host_rd_r <= 1'b0;
                        host_wr_r <= 1'b0;
                        state_r   <= ST_XFER;
                    end
`ifdef FDC_SD_TIMEOUT_EN
                    else if (wd_cnt_r == (TIMEOUT_CYCLES - 24'd1)) begin
                        host_rd_r     <= 1'b0;
                        host_wr_r     <= 1'b0;
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 24'd1;
                    end
`endif
                end
                ST_XFER: begin
                    if (!host_ack) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_grant_r <= grant_r;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Ack and buffer strobe reach only the granted drive, and only mid-transfer.
    always_comb begin
        req_ack     = 4'b0000;
        req_buff_wr = 4'b0000;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (active_s && (grant_r == n[1:0])) begin
                req_ack[n]     = host_ack;
                req_buff_wr[n] = host_buff_wr;
            end else begin
                req_ack[n]     = 1'b0;
                req_buff_wr[n] = 1'b0;
            end
        end
    end

    // Buffer data from the granted drive, zero when idle.
    always_comb begin
        if (busy_r) begin
            host_buff_din = req_buff_din[grant_r];
        end else begin
            host_buff_din = 8'h00;
        end
    end

    assign host_lba   = host_lba_r;
    assign host_drive = grant_r;
    assign host_rd    = host_rd_r;
    assign host_wr    = host_wr_r;
    assign busy       = busy_r;

`ifdef FDC_SD_TIMEOUT_EN
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Directed bench for fdc_sd_arbiter; DUT updates on the falling edge, bench works on the rising edge.
module tb_fdc_sd_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] req_lba [4];
    logic [3:0]  req_rd;
    logic [3:0]  req_wr;
    logic [3:0]  req_ack;
    logic [7:0]  req_buff_din [4];
    logic [3:0]  req_buff_wr;
    logic [31:0] host_lba;
    logic [1:0]  host_drive;
    logic        host_rd;
    logic        host_wr;
    logic        host_ack;
    logic        host_buff_wr;
    logic [7:0]  host_buff_din;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fdc_sd_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr), .req_ack(req_ack),
        .req_buff_din(req_buff_din), .req_buff_wr(req_buff_wr),
        .host_lba(host_lba), .host_drive(host_drive), .host_rd(host_rd), .host_wr(host_wr),
        .host_ack(host_ack), .host_buff_wr(host_buff_wr), .host_buff_din(host_buff_din),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic step();
        @(posedge CLK);
    endtask

    task automatic clear_inputs();
        req_rd       = 4'b0000;
        req_wr       = 4'b0000;
        host_ack     = 1'b0;
        host_buff_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_lba[i]      = 32'd0;
            req_buff_din[i] = 8'h00;
        end
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        clear_inputs();
        step();
        step();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        clear_inputs();
        host_ack     = 1'b1;
        host_buff_wr = 1'b1;
        step();
        checks++; if (host_rd !== 1'b0 || host_wr !== 1'b0) begin errors++; $display("FAIL reset_rdwr: got rd=%b wr=%b want 0 0", host_rd, host_wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (host_lba !== 32'd0 || host_drive !== 2'd0) begin errors++; $display("FAIL reset_lba_drive: got %h %0d want 0 0", host_lba, host_drive); end
        checks++; if (req_ack !== 4'b0000 || req_buff_wr !== 4'b0000) begin errors++; $display("FAIL reset_ack: got ack=%b bwr=%b want 0000", req_ack, req_buff_wr); end
        checks++; if (timeout_err !== 1'b0 || host_buff_din !== 8'h00) begin errors++; $display("FAIL reset_misc: got terr=%b din=%h want 0 00", timeout_err, host_buff_din); end
        RESET_N = 1'b1;
        step();
        // ack and buffer strobe while idle are ignored
        checks++; if (req_ack !== 4'b0000 || req_buff_wr !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got ack=%b bwr=%b busy=%b want 0000 0000 0", req_ack, req_buff_wr, busy); end
        clear_inputs();
    endtask

    task automatic test_basic_read();
        apply_reset();
        req_lba[0] = 32'h12;
        req_rd     = 4'b0001;
        step();
        checks++; if (host_rd !== 1'b1 || host_wr !== 1'b0) begin errors++; $display("FAIL basic_req: got rd=%b wr=%b want 1 0", host_rd, host_wr); end
        checks++; if (host_lba !== 32'h12 || host_drive !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL basic_lba: got lba=%h drv=%0d busy=%b want 12 0 1", host_lba, host_drive, busy); end
        checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL basic_noack: got %b want 0000", req_ack); end
        `ifndef FDC_SD_TIMEOUT_EN
        for (int i = 0; i < 40; i++) step();
        checks++; if (host_rd !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL basic_wait: got rd=%b terr=%b want 1 0", host_rd, timeout_err); end
        `endif
        host_ack     = 1'b1;
        host_buff_wr = 1'b1;
        #1;
        checks++; if (req_ack !== 4'b0001 || req_buff_wr !== 4'b0001) begin errors++; $display("FAIL basic_ack: got ack=%b bwr=%b want 0001 0001", req_ack, req_buff_wr); end
        req_rd     = 4'b0000;
        req_lba[0] = 32'hFFFF_FFFF;
        for (int i = 0; i < 256; i++) begin
            step();
            checks++;
            if (req_ack !== 4'b0001 || req_buff_wr !== 4'b0001 || host_rd !== 1'b0 || host_lba !== 32'h12) begin
                errors++;
                $display("FAIL basic_xfer[%0d]: got ack=%b bwr=%b rd=%b lba=%h want 0001 0001 0 12", i, req_ack, req_buff_wr, host_rd, host_lba);
            end
        end
        host_ack     = 1'b0;
        host_buff_wr = 1'b0;
        step();
        checks++; if (busy !== 1'b1 || req_ack !== 4'b0000) begin errors++; $display("FAIL basic_done: got busy=%b ack=%b want 1 0000", busy, req_ack); end
        host_buff_wr = 1'b1;
        #1;
        checks++; if (req_buff_wr !== 4'b0000) begin errors++; $display("FAIL done_bwr_drop: got %b want 0000", req_buff_wr); end
        host_buff_wr = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_drv;
        logic [3:0] exp_ack;
        int w;
        apply_reset();
        req_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_drv = k[1:0];
            exp_ack = 4'b0001 << exp_drv;
            w = 0;
            while (!busy && w < 8) begin step(); w++; end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_wait[%0d]: got busy=%b want 1", k, busy); end
            checks++; if (host_drive !== exp_drv || host_rd !== 1'b1) begin errors++; $display("FAIL rr_grant[%0d]: got drv=%0d rd=%b want %0d 1", k, host_drive, host_rd, exp_drv); end
            host_ack = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1;
                checks++; if (req_ack !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, req_ack, exp_ack); end
                step();
            end
            host_ack = 1'b0;
            step();
            checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL rr_done[%0d]: got %b want 0000", k, req_ack); end
            step();
        end
        req_rd = 4'b0000;
        step();
    endtask

    task automatic test_write_path();
        apply_reset();
        req_buff_din[2] = 8'hA5;
        req_lba[2]      = 32'hCAFE_0002;
        req_wr          = 4'b0100;
        step();
        checks++; if (host_wr !== 1'b1 || host_rd !== 1'b0 || host_drive !== 2'd2) begin errors++; $display("FAIL wr_req: got wr=%b rd=%b drv=%0d want 1 0 2", host_wr, host_rd, host_drive); end
        checks++; if (host_lba !== 32'hCAFE_0002) begin errors++; $display("FAIL wr_lba: got %h want cafe0002", host_lba); end
        host_ack = 1'b1;
        step();
        req_wr = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++; if (host_buff_din !== 8'hA5 || host_wr !== 1'b0 || req_ack !== 4'b0100) begin errors++; $display("FAIL wr_xfer[%0d]: got din=%h wr=%b ack=%b want a5 0 0100", i, host_buff_din, host_wr, req_ack); end
            step();
        end
        host_ack = 1'b0;
        step();
        step();
        checks++; if (host_buff_din !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got din=%h busy=%b want 00 0", host_buff_din, busy); end
    endtask

    task automatic test_rd_wins();
        apply_reset();
        req_rd = 4'b0010;
        req_wr = 4'b0010;
        step();
        checks++; if (host_rd !== 1'b1 || host_wr !== 1'b0 || host_drive !== 2'd1) begin errors++; $display("FAIL rd_wins: got rd=%b wr=%b drv=%0d want 1 0 1", host_rd, host_wr, host_drive); end
        host_ack = 1'b1;
        step();
        req_rd = 4'b0000;
        req_wr = 4'b0000;
        host_ack = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_xfer();
        apply_reset();
        req_rd = 4'b0101;
        step();
        checks++; if (host_drive !== 2'd0) begin errors++; $display("FAIL rst_first: got drv=%0d want 0", host_drive); end
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();
        step();
        step();
        checks++; if (host_drive !== 2'd2 || host_rd !== 1'b1) begin errors++; $display("FAIL rst_second: got drv=%0d rd=%b want 2 1", host_drive, host_rd); end
        host_ack = 1'b1;
        step();
        RESET_N = 1'b0;
        #1;
        checks++; if (host_rd !== 1'b0 || host_wr !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000) begin errors++; $display("FAIL rst_mid: got rd=%b wr=%b busy=%b ack=%b want 0 0 0 0000", host_rd, host_wr, busy, req_ack); end
        host_ack = 1'b0;
        step();
        RESET_N = 1'b1;
        step();
        checks++; if (host_drive !== 2'd0 || host_rd !== 1'b1) begin errors++; $display("FAIL rst_after: got drv=%0d rd=%b want 0 1", host_drive, host_rd); end
        req_rd = 4'b0000;
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();
        step();
    endtask

`ifdef FDC_SD_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        apply_reset();
        req_rd = 4'b0011;
        step();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (timeout_err === 1'b1) pulses++;
        end
        checks++; if (host_rd !== 1'b1 || host_drive !== 2'd0) begin errors++; $display("FAIL to_hold: got rd=%b drv=%0d want 1 0", host_rd, host_drive); end
        step();
        checks++; if (host_rd !== 1'b0 || timeout_err !== 1'b1 || req_ack !== 4'b0000) begin errors++; $display("FAIL to_abort: got rd=%b terr=%b ack=%b want 0 1 0000", host_rd, timeout_err, req_ack); end
        step();
        checks++; if (timeout_err !== 1'b0 || pulses !== 0) begin errors++; $display("FAIL to_pulse: got terr=%b early=%0d want 0 0", timeout_err, pulses); end
        step();
        checks++; if (host_drive !== 2'd1 || host_rd !== 1'b1) begin errors++; $display("FAIL to_next: got drv=%0d rd=%b want 1 1", host_drive, host_rd); end
        req_rd = 4'b0000;
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_read();
        test_round_robin();
        test_write_path();
        test_rd_wins();
        test_reset_mid_xfer();
`ifdef FDC_SD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fdc_sd_arbiter.md
Name: fdc_sd_arbiter

Overview:
- Serialises the four per-drive wd1793 SD block requests onto one shared SD block port (single virtual-disk host channel).
- Sits between the four drive controllers and the host SD interface.
- Grants one drive at a time, using round-robin order.
- Routes LBA, read/write strobes, ack, and the buffer data path to and from the granted drive only.

Parameters:
- NUM_REQ, 4, number of requesting drives; fixed at 4, index width 2.
- TIMEOUT_CYCLES, 24'd5000000, CLK cycles allowed between host request and host_ack. Used only with FDC_SD_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock; all registers update on the falling edge.
- RESET_N  input  1  asynchronous, active-low reset.
- req_lba[4]  input  32 each  per-drive block LBA.
- req_rd  input  4  per-drive read request (level, held until ack).
- req_wr  input  4  per-drive write request (level, held until ack).
- req_ack  output  4  per-drive ack, routed from host_ack.
- req_buff_din[4]  input  8 each  per-drive buffer read data (write-to-SD path).
- req_buff_wr  output  4  per-drive gated buffer write strobe.
- host_lba  output  32  LBA of the granted drive.
- host_drive  output  2  index of the granted drive.
- host_rd  output  1  host block read request.
- host_wr  output  1  host block write request.
- host_ack  input  1  host transfer-active acknowledge.
- host_buff_wr  input  1  host buffer write strobe.
- host_buff_din  output  8  buffer data from the granted drive.
- busy  output  1  arbiter not in IDLE.
- timeout_err  output  1  one-cycle pulse on watchdog abort; 0 when the feature is out.

Behaviour:
- Reset values: state=IDLE, grant=0, last_grant=3 (so drive 0 has first priority), host_rd=host_wr=0, host_lba=0, host_drive=0, busy=0, timeout_err=0. All req_ack and req_buff_wr are 0.
- pending[n] = req_rd[n] | req_wr[n].
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - Search starts at last_grant+1 (mod 4) and takes the first pending drive.
  - On the same edge, latch grant, host_lba=req_lba[grant] and op. Read wins if req_rd and req_wr are both high.
  - Set host_rd or host_wr; go to REQ.
  - Latency from a request sampled in IDLE to host_rd/host_wr high: 1 edge.
- REQ:
  - host_rd/host_wr are held.
  - On the edge where host_ack is sampled 1: clear host_rd/host_wr; go to XFER.
  - If the requester drops its request in REQ, the host request is still completed; the host cannot cancel.
- XFER:
  - Stays while host_ack=1.
  - On host_ack sampled 0: go to DONE.
- DONE:
  - One idle cycle; set last_grant=grant; go to IDLE.
  - Guarantees the requester sees req_ack low before re-arbitration.
- Routing (combinational, from registered grant/state):
  - req_ack[n] = host_ack & (state is REQ or XFER) & (grant==n).
  - req_buff_wr[n] = host_buff_wr & (state is REQ or XFER) & (grant==n).
  - host_buff_din = req_buff_din[grant] when busy, else 8'h00.
  - host_drive = grant.
- Fairness: with all four requesting continuously, grants go 0,1,2,3,0,…. No drive waits more than 3 transfers.
- Input changes while busy: req_lba changes are ignored (latched value is used). New requests queue implicitly as levels.
- host_ack high while IDLE or DONE: ignored; no req_ack is generated.
- host_buff_wr outside REQ/XFER: dropped.
- Reset asserted mid-transfer: immediate return to reset values; the host sees its request withdrawn.

Optional Feature:
- Macro: FDC_SD_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to REQ and increments each cycle in REQ.
  - On reaching TIMEOUT_CYCLES-1 with host_ack still 0: clear host_rd/host_wr, pulse timeout_err for 1 cycle, go to DONE.
  - The granted drive gets no ack and may re-request.
- Undefined: no counter; REQ waits indefinitely; timeout_err is tied to 0.

Test Plan:
- Reset, then req_rd=4'b0001 with req_lba[0]=32'h12 → host_rd=1, host_lba=32'h12, host_drive=0 one edge later. Host ack pulse of 256 cycles with host_buff_wr → req_ack[0] and req_buff_wr[0] only; busy falls 1 cycle after ack falls.
- req_rd=4'b1111 held, host acks each request → grant order 0,1,2,3,0. Never two req_ack bits high at once.
- req_wr[2]=1, req_buff_din[2]=8'hA5, others 8'h00 → host_wr=1, host_drive=2, host_buff_din=8'hA5 throughout XFER.
- req_rd[1] and req_wr[1] both 1 → host_rd=1, host_wr=0.
- Assert RESET_N=0 during XFER → host_rd=host_wr=0, req_ack=0, busy=0 immediately. After release, drive 0 wins if pending.
- With FDC_SD_TIMEOUT_EN and TIMEOUT_CYCLES=16, request with no host_ack → host_rd drops after 16 cycles in REQ, timeout_err pulses once, next pending drive granted.
